// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled sclk/ss_n/mosi, MSB-first words,
// status word shifted out on miso while the received word assembles.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_load,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_load_q, tx_load_d;
  logic              ferr_q, ferr_d;

  // Synchronizer chains plus one delay stage for edge detection.
  // ss chain clears low so a low ss_n at release is never a fresh select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;

  assign cnt_inc = cnt_q + 1'b1;
  assign rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};

  // State, shifters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      ferr_q     <= ferr_d;
    end
  end

  // Next state: ss rise wins over any sclk edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        oe_d   = 1'b0;
        if (ss_fall) begin
          state_d    = SHIFT;
          rx_shift_d = '0;
          tx_shift_d = tx_data;
          tx_load_d  = 1'b1;
          miso_d     = tx_data[DATA_W-1];
          oe_d       = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
          oe_d    = 1'b0;
          ferr_d  = (cnt_q != '0);
        end else if (sclk_rise) begin
          rx_shift_d = rx_next;
          if (cnt_inc == CNT_FULL) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (sclk_fall) begin
          if (cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end else begin
            tx_shift_d = tx_data;
            tx_load_d  = 1'b1;
            miso_d     = tx_data[DATA_W-1];
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_load   = tx_load_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: event-level SPI model schedules expected outputs
// SYNC+1 cycles after each pin event; compared every cycle.
module tb_spi_slave;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int L    = SYNC + 1;
  localparam int MAXC = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         ss_n;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_load;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  spi_slave #(.DATA_W(W), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scheduled expectations, indexed by cycle
  bit         ev_miso_v[MAXC];
  bit         ev_miso[MAXC];
  bit         ev_oe_v[MAXC];
  bit         ev_oe[MAXC];
  bit         ev_rxd_v[MAXC];
  bit [W-1:0] ev_rxd[MAXC];
  bit         p_rxv[MAXC];
  bit         p_txl[MAXC];
  bit         p_ferr[MAXC];

  // abstract frame model
  bit         m_sel;
  bit         m_armed;
  int         m_cnt;
  bit [W-1:0] m_rx;
  bit [W-1:0] m_tx;

  // observations
  int         n_rxv = 0;
  int         n_txl = 0;
  int         n_ferr = 0;
  int         last_rxv_cyc = 0;
  int         last_rise_cyc = 0;
  bit [W-1:0] rxq[$];
  int         txlq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // per-cycle compare against the model
  initial begin : cmp
    bit         e_miso;
    bit         e_oe;
    bit [W-1:0] e_rxd;
    bit         x_rxv;
    bit         x_txl;
    bit         x_ferr;
    e_miso = 0;
    e_oe   = 0;
    e_rxd  = 0;
    forever begin
      @(negedge clk);
      x_rxv  = 0;
      x_txl  = 0;
      x_ferr = 0;
      if (!rst) begin
        e_miso = 0;
        e_oe   = 0;
        e_rxd  = 0;
      end else if (cyc < MAXC) begin
        if (ev_miso_v[cyc]) e_miso = ev_miso[cyc];
        if (ev_oe_v[cyc])   e_oe   = ev_oe[cyc];
        if (ev_rxd_v[cyc])  e_rxd  = ev_rxd[cyc];
        x_rxv  = p_rxv[cyc];
        x_txl  = p_txl[cyc];
        x_ferr = p_ferr[cyc];
      end
      chk("miso", 32'(miso), 32'(e_miso));
      chk("miso_oe", 32'(miso_oe), 32'(e_oe));
      chk("busy", 32'(busy), 32'(e_oe));
      chk("rx_data", 32'(rx_data), 32'(e_rxd));
      chk("rx_valid", 32'(rx_valid), 32'(x_rxv));
      chk("tx_load", 32'(tx_load), 32'(x_txl));
      chk("frame_err", 32'(frame_err), 32'(x_ferr));
      if (rx_valid === 1'b1) begin
        n_rxv++;
        rxq.push_back(rx_data);
        last_rxv_cyc = cyc;
      end
      if (tx_load === 1'b1) begin
        n_txl++;
        txlq.push_back(cyc);
      end
      if (frame_err === 1'b1) n_ferr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_miso(input int t, input bit v);
    ev_miso_v[t] = 1;
    ev_miso[t]   = v;
  endtask

  task automatic set_oe(input int t, input bit v);
    ev_oe_v[t] = 1;
    ev_oe[t]   = v;
  endtask

  task automatic pin_ss(input bit v);
    int t;
    t = cyc + L;
    ss_n = v;
    if (!v) begin
      if (m_armed && !m_sel) begin
        m_sel   = 1;
        m_armed = 0;
        m_cnt   = 0;
        m_tx    = tx_data;
        set_miso(t, m_tx[W-1]);
        set_oe(t, 1);
        p_txl[t] = 1;
      end
    end else begin
      m_armed = 1;
      if (m_sel) begin
        m_sel = 0;
        set_miso(t, 0);
        set_oe(t, 0);
        if (m_cnt != 0) p_ferr[t] = 1;
        m_cnt = 0;
      end
    end
  endtask

  task automatic pin_sclk(input bit v);
    int t;
    t = cyc + L;
    sclk = v;
    if (v) last_rise_cyc = cyc;
    if (m_sel) begin
      if (v) begin
        m_rx = {m_rx[W-2:0], mosi};
        m_cnt++;
        if (m_cnt == W) begin
          ev_rxd_v[t] = 1;
          ev_rxd[t]   = m_rx;
          p_rxv[t]    = 1;
          m_cnt       = 0;
        end
      end else if (m_cnt == 0) begin
        m_tx = tx_data;
        p_txl[t] = 1;
        set_miso(t, m_tx[W-1]);
      end else begin
        set_miso(t, m_tx[W-1-m_cnt]);
      end
    end
  endtask

  // sclk rise and ss rise land in the same synchronized cycle
  task automatic coincident();
    sclk = 1'b1;
    pin_ss(1'b1);
  endtask

  task automatic rst_assert();
    rst = 1'b0;
    for (int i = cyc; i < MAXC; i++) begin
      ev_miso_v[i] = 0;
      ev_oe_v[i]   = 0;
      ev_rxd_v[i]  = 0;
      p_rxv[i]     = 0;
      p_txl[i]     = 0;
      p_ferr[i]    = 0;
    end
    m_sel   = 0;
    m_cnt   = 0;
    m_armed = 0;
  endtask

  task automatic rst_release();
    rst = 1'b1;
    m_armed = ss_n;
  endtask

  task automatic send_bits(input bit [W-1:0] b, input int n,
                           output bit [W-1:0] mw);
    mw = '0;
    for (int i = 0; i < n; i++) begin
      mosi = b[W-1-i];
      tick(4);
      mw = {mw[W-2:0], miso};
      pin_sclk(1'b1);
      tick(4);
      pin_sclk(1'b0);
    end
  endtask

  initial begin : stim
    bit [W-1:0] mw;
    bit [W-1:0] mw2;
    int         mark;
    int         markf;
    int         ssf;
    rst     = 1'b1;
    ss_n    = 1'b1;
    sclk    = 1'b0;
    mosi    = 1'b0;
    tx_data = '0;
    #1;
    rst_assert();
    tick(3);
    pin_sclk(1'b1);
    tick(2);
    pin_sclk(1'b0);
    tick(2);
    rst_release();
    for (int i = 0; i < 4; i++) begin
      tick(4);
      pin_sclk(1'b1);
      tick(4);
      pin_sclk(1'b0);
    end
    tick(6);
    chk("idle_rxv_none", 32'(n_rxv), 32'd0);
    chk("idle_txl_none", 32'(n_txl), 32'd0);

    // single word
    tx_data = 8'h3C;
    mark = n_rxv;
    markf = n_txl;
    ssf = cyc;
    pin_ss(1'b0);
    tick(8);
    send_bits(8'hA5, 8, mw);
    tick(4);
    pin_ss(1'b1);
    tick(8);
    chk("f1_rx_data", 32'(rx_data), 32'h0000_00A5);
    chk("f1_rxv_count", 32'(n_rxv - mark), 32'd1);
    chk("f1_miso_word", 32'(mw), 32'h0000_003C);
    chk("f1_rxv_latency", 32'(last_rxv_cyc - last_rise_cyc), 32'd3);
    chk("f1_txl_at_ss", 32'(txlq[markf] - ssf), 32'd3);

    // two words in one frame
    tx_data = 8'h55;
    mark = n_rxv;
    markf = n_txl;
    pin_ss(1'b0);
    tick(4);
    chk("f2_first_txl", 32'(n_txl - markf), 32'd1);
    tx_data = 8'hAA;
    tick(4);
    send_bits(8'h12, 8, mw);
    send_bits(8'hFE, 8, mw2);
    tick(4);
    pin_ss(1'b1);
    tick(8);
    chk("f2_rxv_count", 32'(n_rxv - mark), 32'd2);
    chk("f2_rx_first", 32'(rxq[mark]), 32'h0000_0012);
    chk("f2_rx_second", 32'(rxq[mark+1]), 32'h0000_00FE);
    chk("f2_miso_first", 32'(mw), 32'h0000_0055);
    chk("f2_miso_second", 32'(mw2), 32'h0000_00AA);

    // partial word after a full one
    tx_data = 8'h00;
    pin_ss(1'b0);
    tick(8);
    send_bits(8'h77, 8, mw);
    send_bits(8'hA8, 5, mw);
    tick(4);
    markf = n_ferr;
    pin_ss(1'b1);
    tick(L);
    chk("f3_oe_off", 32'(miso_oe), 32'd0);
    tick(8);
    chk("f3_ferr_count", 32'(n_ferr - markf), 32'd1);
    chk("f3_rx_kept", 32'(rx_data), 32'h0000_0077);

    // reset in the middle of a frame
    tx_data = 8'h99;
    pin_ss(1'b0);
    tick(8);
    send_bits(8'hF0, 4, mw);
    tick(1);
    markf = n_ferr;
    rst_assert();
    #1;
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    tick(3);
    rst_release();
    mark = n_rxv;
    send_bits(8'h5A, 8, mw);
    tick(4);
    chk("rst_no_rxv", 32'(n_rxv - mark), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);
    chk("rst_no_ferr", 32'(n_ferr - markf), 32'd0);
    pin_ss(1'b1);
    tick(8);
    pin_ss(1'b0);
    tick(8);
    send_bits(8'h81, 8, mw);
    tick(4);
    pin_ss(1'b1);
    tick(8);
    chk("rst_new_frame", 32'(rx_data), 32'h0000_0081);

    // sclk rise coincident with ss rise, mid-word
    tx_data = 8'hC3;
    mark = n_rxv;
    markf = n_ferr;
    pin_ss(1'b0);
    tick(8);
    send_bits(8'hE0, 3, mw);
    mosi = 1'b1;
    tick(4);
    coincident();
    tick(8);
    pin_sclk(1'b0);
    tick(8);
    chk("co_mid_ferr", 32'(n_ferr - markf), 32'd1);
    chk("co_mid_rxv", 32'(n_rxv - mark), 32'd0);
    chk("co_mid_rx", 32'(rx_data), 32'h0000_0081);

    // same, at a word boundary
    mark = n_rxv;
    markf = n_ferr;
    pin_ss(1'b0);
    tick(8);
    send_bits(8'h0F, 8, mw);
    mosi = 1'b1;
    tick(4);
    coincident();
    tick(8);
    pin_sclk(1'b0);
    tick(8);
    chk("co_wb_ferr", 32'(n_ferr - markf), 32'd0);
    chk("co_wb_rxv", 32'(n_rxv - mark), 32'd1);
    chk("co_wb_rx", 32'(rx_data), 32'h0000_000F);
    chk("co_wb_miso", 32'(mw), 32'h0000_00C3);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
